// File: rtl/seq_shift_right.sv
// Multi-cycle 32-bit right shifter: one shift-amount bit per clock (16/8/4/2/1)
// through a single shared stage, logical or arithmetic fill.
module seq_shift_right (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_shift,
    input  logic        ctrl_arith,
    input  logic [31:0] dataIn,
    input  logic [4:0]  shiftamt,
    output logic [31:0] dataOut,
    output logic        data_resultRDY,
    output logic        busy
);

    // Handshake: a request is accepted on any rising edge where ctrl_shift=1 and
    // busy=0; busy then stays high for exactly five cycles, and data_resultRDY
    // pulses for one cycle with dataOut valid. Requests while busy are dropped.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  stage;
    logic [31:0] work;
    logic [4:0]  amt;
    logic        fill;

    logic        accept;
    logic        last_stage;
    logic        stage_sel;
    logic [31:0] shifted;
    logic [31:0] stage_out;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_stage = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_shift) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (stage == 3'd4) begin
                    last_stage = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage k shifts by 16>>k when amount bit 4-k is set; vacated bits take fill.
    always_comb begin
        shifted   = work;
        stage_sel = 1'b0;
        case (stage)
            3'd0: begin shifted = {{16{fill}}, work[31:16]}; stage_sel = amt[4]; end
            3'd1: begin shifted = {{8{fill}},  work[31:8]};  stage_sel = amt[3]; end
            3'd2: begin shifted = {{4{fill}},  work[31:4]};  stage_sel = amt[2]; end
            3'd3: begin shifted = {{2{fill}},  work[31:2]};  stage_sel = amt[1]; end
            3'd4: begin shifted = {fill,       work[31:1]};  stage_sel = amt[0]; end
            default: begin shifted = work; stage_sel = 1'b0; end
        endcase
        stage_out = stage_sel ? shifted : work;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage          <= 3'd0;
            work           <= 32'h0;
            amt            <= 5'd0;
            fill           <= 1'b0;
            dataOut        <= 32'h0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= last_stage;
            if (accept) begin
                work  <= dataIn;
                amt   <= shiftamt;
                fill  <= ctrl_arith & dataIn[31];
                stage <= 3'd0;
            end else if (state == SHIFT) begin
                work <= stage_out;
                if (last_stage) begin
                    dataOut <= stage_out;
                    stage   <= 3'd0;
                end else begin
                    stage <= stage + 3'd1;
                end
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_seq_shift_right.sv
// Directed testbench for seq_shift_right: reset, logical/arithmetic shifts,
// amount sweep, start-while-busy, back-to-back issue and mid-operation reset.
module tb_seq_shift_right;

    logic        clock;
    logic        reset_n;
    logic        ctrl_shift;
    logic        ctrl_arith;
    logic [31:0] dataIn;
    logic [4:0]  shiftamt;
    logic [31:0] dataOut;
    logic        data_resultRDY;
    logic        busy;

    int pass_cnt;
    int total_cnt;

    seq_shift_right dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_shift     (ctrl_shift),
        .ctrl_arith     (ctrl_arith),
        .dataIn         (dataIn),
        .shiftamt       (shiftamt),
        .dataOut        (dataOut),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issues one request from the current point (1 time unit after an edge) and
    // waits for the completion pulse, which leaves the bench in the pulse cycle.
    task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic arith,
                          output logic [31:0] res, output int busy_cycles,
                          output logic ok, output logic held);
        logic [31:0] prev;
        prev        = dataOut;
        held        = 1'b1;
        ok          = 1'b0;
        busy_cycles = 0;
        dataIn      = d;
        shiftamt    = a;
        ctrl_arith  = arith;
        ctrl_shift  = 1'b1;
        @(posedge clock); #1;
        ctrl_shift  = 1'b0;
        dataIn      = $urandom;
        shiftamt    = 5'($urandom_range(0, 31));
        ctrl_arith  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 20; i++) begin
            if (data_resultRDY) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (dataOut !== prev) held = 1'b0;
            @(posedge clock); #1;
        end
        res = dataOut;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        ctrl_shift = 1'b0;
        ctrl_arith = 1'b0;
        dataIn     = 32'h0;
        shiftamt   = 5'd0;
        repeat (3) @(posedge clock);
        #1;
        total_cnt++;
        if (dataOut !== 32'h0 || busy !== 1'b0 || data_resultRDY !== 1'b0)
            $display("FAIL reset_state: dataOut=%h busy=%b rdy=%b, required 00000000/0/0",
                     dataOut, busy, data_resultRDY);
        else pass_cnt++;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_logical();
        logic [31:0] res; int bc; logic ok; logic held;
        run_op(32'h80000000, 5'd4, 1'b0, res, bc, ok, held);
        total_cnt++;
        if (!ok || res !== 32'h08000000)
            $display("FAIL logical_result: ok=%b dataOut=%h, required 08000000", ok, res);
        else pass_cnt++;
        total_cnt++;
        if (bc !== 5) $display("FAIL logical_busy_cycles: got %0d, required 5", bc);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL logical_busy_at_done: busy=%b, required 0", busy);
        else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++;
        if (data_resultRDY !== 1'b0 || dataOut !== 32'h08000000)
            $display("FAIL logical_pulse_width: rdy=%b dataOut=%h, required 0/08000000",
                     data_resultRDY, dataOut);
        else pass_cnt++;
    endtask

    task automatic test_arith();
        logic [31:0] res; int bc; logic ok; logic held;
        run_op(32'h80000000, 5'd4, 1'b1, res, bc, ok, held);
        total_cnt++;
        if (!ok || res !== 32'hF8000000)
            $display("FAIL arith_neg4: ok=%b dataOut=%h, required f8000000", ok, res);
        else pass_cnt++;
        @(posedge clock); #1;
        run_op(32'h80000001, 5'd31, 1'b1, res, bc, ok, held);
        total_cnt++;
        if (!ok || res !== 32'hFFFFFFFF)
            $display("FAIL arith_neg31: ok=%b dataOut=%h, required ffffffff", ok, res);
        else pass_cnt++;
        @(posedge clock); #1;
        run_op(32'h7FFFFFFF, 5'd31, 1'b1, res, bc, ok, held);
        total_cnt++;
        if (!ok || res !== 32'h00000000)
            $display("FAIL arith_pos31: ok=%b dataOut=%h, required 00000000", ok, res);
        else pass_cnt++;
        @(posedge clock); #1;
    endtask

    task automatic test_identity();
        logic [31:0] res; int bc; logic ok; logic held;
        run_op(32'hDEADBEEF, 5'd0, 1'b1, res, bc, ok, held);
        total_cnt++;
        if (!ok || res !== 32'hDEADBEEF || bc !== 5)
            $display("FAIL identity: ok=%b dataOut=%h busy_cycles=%0d, required deadbeef/5",
                     ok, res, bc);
        else pass_cnt++;
        @(posedge clock); #1;
    endtask

    task automatic test_sweep();
        logic [31:0] res; int bc; logic ok; logic held;
        logic [31:0] exp_val;
        logic [31:0] pattern;
        pattern = 32'hA5A5A5A5;
        for (int ar = 0; ar < 2; ar++) begin
            for (int a = 0; a < 32; a++) begin
                if (ar == 1) exp_val = 32'($signed(pattern) >>> a);
                else         exp_val = pattern >> a;
                run_op(pattern, 5'(a), 1'(ar), res, bc, ok, held);
                total_cnt++;
                if (!ok || res !== exp_val)
                    $display("FAIL sweep arith=%0d amt=%0d: ok=%b dataOut=%h, required %h",
                             ar, a, ok, res, exp_val);
                else pass_cnt++;
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic test_start_while_busy();
        int pulses;
        dataIn     = 32'h0000FF00;
        shiftamt   = 5'd8;
        ctrl_arith = 1'b0;
        ctrl_shift = 1'b1;
        @(posedge clock); #1;
        ctrl_shift = 1'b0;
        @(posedge clock); #1;
        dataIn     = 32'hFFFFFFFF;
        shiftamt   = 5'd1;
        ctrl_arith = 1'b1;
        ctrl_shift = 1'b1;
        @(posedge clock); #1;
        ctrl_shift = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (data_resultRDY) pulses++;
            @(posedge clock); #1;
        end
        total_cnt++;
        if (dataOut !== 32'h000000FF)
            $display("FAIL busy_ignore_result: dataOut=%h, required 000000ff", dataOut);
        else pass_cnt++;
        total_cnt++;
        if (pulses !== 1) $display("FAIL busy_ignore_pulses: got %0d, required 1", pulses);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; int bc; logic ok; logic held;
        run_op(32'h00000100, 5'd4, 1'b0, res, bc, ok, held);
        total_cnt++;
        if (!ok || res !== 32'h00000010)
            $display("FAIL b2b_first: ok=%b dataOut=%h, required 00000010", ok, res);
        else pass_cnt++;
        // Issued in the completion-pulse cycle of the previous operation.
        run_op(32'h00000010, 5'd4, 1'b0, res, bc, ok, held);
        total_cnt++;
        if (!ok || res !== 32'h00000001 || bc !== 5)
            $display("FAIL b2b_second: ok=%b dataOut=%h busy_cycles=%0d, required 00000001/5",
                     ok, res, bc);
        else pass_cnt++;
        total_cnt++;
        if (!held) $display("FAIL b2b_hold: held=%b, required 1", held);
        else pass_cnt++;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res; int bc; logic ok; logic held;
        int pulses;
        dataIn     = 32'h12345678;
        shiftamt   = 5'd3;
        ctrl_arith = 1'b0;
        ctrl_shift = 1'b1;
        @(posedge clock); #1;
        ctrl_shift = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (dataOut !== 32'h0 || busy !== 1'b0 || data_resultRDY !== 1'b0)
            $display("FAIL reset_mid_op: dataOut=%h busy=%b rdy=%b, required 00000000/0/0",
                     dataOut, busy, data_resultRDY);
        else pass_cnt++;
        @(posedge clock); #1;
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (data_resultRDY || busy) pulses++;
            @(posedge clock); #1;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL reset_no_pulse: activity cycles %0d, required 0", pulses);
        else pass_cnt++;
        run_op(32'h12345678, 5'd3, 1'b0, res, bc, ok, held);
        total_cnt++;
        if (!ok || res !== 32'h02468ACF)
            $display("FAIL reset_recover: ok=%b dataOut=%h, required 02468acf", ok, res);
        else pass_cnt++;
        @(posedge clock); #1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_logical();
        test_arith();
        test_identity();
        test_sweep();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seq_shift_right.md
# seq_shift_right

Multi-cycle 32-bit right shifter, the right-shift companion to the combinational left barrel shifter in the ALU datapath. It supports logical right shift (zero fill) and arithmetic right shift (sign fill). It resolves one shift-amount bit per clock, 16/8/4/2/1, through a single shared stage, which trades latency for area. It sits beside the multdiv unit and uses the same start/busy/result-ready handshake style, so the processor's stall logic treats both units identically.

## Interface
- No parameters; width fixed at 32 bits, shift amount fixed at 5 bits.
- clock  input  1  rising-edge system clock
- reset_n  input  1  asynchronous, active-low reset
- ctrl_shift  input  1  start request; sampled on a rising edge while busy=0
- ctrl_arith  input  1  fill select, latched on accept: 1 = sign fill with dataIn[31], 0 = zero fill
- dataIn  input  32  operand, latched on accept
- shiftamt  input  5  shift amount 0..31, latched on accept
- dataOut  output  32  registered result of the last completed operation
- data_resultRDY  output  1  one-cycle pulse marking dataOut newly valid
- busy  output  1  high while an operation is in flight

## Operation
- State machine:
  - IDLE: busy=0. ctrl_shift=1 at the edge → capture work=dataIn, amt=shiftamt, fill=ctrl_arith ? dataIn[31] : 0, stage counter=0; go to SHIFT.
  - SHIFT: busy=1. Each edge applies stage k (k=0..4; shift distance 16>>k). Condition: amt[4-k]=1 → work = work >> (16>>k), with vacated upper bits = fill; else work unchanged. Counter increments each edge.
  - After stage 4: the same edge loads dataOut=work result and sets data_resultRDY=1, busy=0; go to IDLE.
- Latency is always 5 edges after accept, including shiftamt=0; there is no early exit.
- ctrl_shift while busy=1: ignored. Latched operands do not change; no queueing.
- ctrl_shift=1 in the cycle data_resultRDY=1: accepted, because busy is already 0. This gives back-to-back issue at one operation per 6 cycles.
- dataOut holds its value through subsequent operations and changes only on a completion edge.
- data_resultRDY is high for exactly one cycle per completed operation.
- Inputs other than ctrl_shift are don't-care outside the accept edge.
- Arithmetic shift of a positive operand equals logical shift. Arithmetic shift by 31 yields 0x00000000 or 0xFFFFFFFF.

## Timing
- Reset, asynchronous on reset_n=0: state=IDLE, counter=0, work=0, dataOut=0x00000000, data_resultRDY=0, busy=0. These values take effect immediately, without waiting for a clock edge.
- Reset asserted mid-operation: the in-flight operation is discarded and no data_resultRDY is produced. The first accept after deassertion is at the first rising edge with reset_n=1 and ctrl_shift=1.
- Accept at edge t0. busy rises after t0. Stages complete at edges t1..t5. After t5: dataOut valid, data_resultRDY=1, busy=0. At t6: data_resultRDY returns to 0 unless a new completion occurs.
- All outputs are registered; none depends combinationally on inputs.
- Width rule: internal shifts never exceed 31 total bits; no intermediate exceeds 32 bits.

## Test plan
- Logical shift: dataIn=0x80000000, shiftamt=4, arith=0 → after 5 edges dataOut=0x08000000, one-cycle data_resultRDY, busy high for exactly 5 cycles.
- Arithmetic shift: dataIn=0x80000000, shiftamt=4, arith=1 → dataOut=0xF8000000. Then dataIn=0x80000001, shiftamt=31, arith=1 → 0xFFFFFFFF. Then dataIn=0x7FFFFFFF, shiftamt=31, arith=1 → 0x00000000.
- Identity and full stage coverage: shiftamt=0 on 0xDEADBEEF → 0xDEADBEEF after 5 edges. Sweep shiftamt 0..31 on 0xA5A5A5A5 with both fills against a software model.
- Start while busy: issue 0x0000FF00>>8 logical, then pulse ctrl_shift with dataIn=0xFFFFFFFF, shiftamt=1 on cycle 2 → result 0x000000FF, only one data_resultRDY pulse.
- Back-to-back: raise ctrl_shift (0x00000010>>4) in the data_resultRDY cycle of a prior op → accepted. Result 0x00000001 arrives 5 edges later; the earlier dataOut is held until then.
- Reset mid-op: accept 0x12345678>>3, drop reset_n after edge t2 → dataOut=0, busy=0, data_resultRDY=0 immediately. No pulse after release. A new op after release completes correctly.
